// File: rtl/icap_stream_ctrl.sv
// ICAP stream controller: bridges a valid/ready write stream and a counted
// readback request onto the ICAP configuration port.
// Build option: define ICAP_BITSWAP_EN to reverse the bit order within each
// byte on both the write data (cdata) and the readback data (rb_data).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | deselected; waits for rd_start (priority) or s_valid
// WR_TURN | one deselected cycle with cwe_n low before write data
// WRITE   | streams accepted words to cdata, stalls on cbusy
// WR_END  | last word issued; deselect with cwe_n still low, then IDLE
// RD_TURN | one deselected cycle with cwe_n high before reading
// READ    | selected for read; captures cdata_rb when cbusy is low
// RD_END  | one deselected cycle, then IDLE with rd_done
module icap_stream_ctrl #(
    parameter int RD_LEN_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    input  logic [31:0]         s_data,
    input  logic                s_last,
    output logic                s_ready,
    input  logic                rd_start,
    input  logic [RD_LEN_W-1:0] rd_len,
    output logic                rb_valid,
    output logic [31:0]         rb_data,
    output logic                wr_done,
    output logic                rd_done,
    output logic                cclk,
    output logic                ccs_n,
    output logic                cwe_n,
    output logic [31:0]         cdata,
    input  logic                cbusy,
    input  logic [31:0]         cdata_rb
);

    typedef enum logic [2:0] {
        IDLE,
        WR_TURN,
        WRITE,
        WR_END,
        RD_TURN,
        READ,
        RD_END
    } state_t;

    state_t                state, state_d;
    logic [RD_LEN_W-1:0]   cnt, cnt_d;
    logic                  ccs_n_d, cwe_n_d;
    logic [31:0]           cdata_d, rb_data_d;
    logic                  rb_valid_d, wr_done_d, rd_done_d;

    // Optional per-byte bit reversal shared by the write and readback paths.
    function automatic logic [31:0] icap_map(input logic [31:0] d);
`ifdef ICAP_BITSWAP_EN
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b+i] = d[8*b+7-i];
            end
        end
        return r;
`else
        return d;
`endif
    endfunction

    // The ICAP clock is the system clock itself.
    assign cclk = clk;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Registered ICAP strobes, data, readback outputs, pulses and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccs_n    <= 1'b1;
            cwe_n    <= 1'b1;
            cdata    <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
            wr_done  <= 1'b0;
            rd_done  <= 1'b0;
            cnt      <= '0;
        end else begin
            ccs_n    <= ccs_n_d;
            cwe_n    <= cwe_n_d;
            cdata    <= cdata_d;
            rb_data  <= rb_data_d;
            rb_valid <= rb_valid_d;
            wr_done  <= wr_done_d;
            rd_done  <= rd_done_d;
            cnt      <= cnt_d;
        end
    end

    // Next state and next values of the registered outputs. The strobes
    // computed here describe the ICAP bus cycle that follows, so the write
    // data lands one cycle after its handshake.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        ccs_n_d    = 1'b1;
        cwe_n_d    = 1'b1;
        cdata_d    = cdata;
        rb_data_d  = rb_data;
        rb_valid_d = 1'b0;
        wr_done_d  = 1'b0;
        rd_done_d  = 1'b0;
        s_ready    = 1'b0;

        unique case (state)
            IDLE: begin
                if (rd_start) begin
                    if (rd_len != '0) begin
                        cnt_d   = rd_len;
                        state_d = RD_TURN;
                    end else begin
                        rd_done_d = 1'b1;
                    end
                end else if (s_valid) begin
                    // Lower cwe_n while still deselected.
                    cwe_n_d = 1'b0;
                    state_d = WR_TURN;
                end
            end
            WR_TURN: begin
                cwe_n_d = 1'b0;
                state_d = WRITE;
            end
            WRITE: begin
                s_ready = !cbusy;
                cwe_n_d = 1'b0;
                if (s_valid && !cbusy) begin
                    ccs_n_d = 1'b0;
                    cdata_d = icap_map(s_data);
                    if (s_last) begin
                        state_d = WR_END;
                    end
                end
            end
            WR_END: begin
                cwe_n_d   = 1'b0;
                wr_done_d = 1'b1;
                state_d   = IDLE;
            end
            RD_TURN: begin
                ccs_n_d = 1'b0;
                state_d = READ;
            end
            READ: begin
                ccs_n_d = 1'b0;
                if (!cbusy) begin
                    rb_data_d  = icap_map(cdata_rb);
                    rb_valid_d = 1'b1;
                    cnt_d      = cnt - RD_LEN_W'(1);
                    if (cnt == RD_LEN_W'(1)) begin
                        ccs_n_d = 1'b1;
                        state_d = RD_END;
                    end
                end
            end
            RD_END: begin
                rd_done_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icap_stream_ctrl.sv
// Self-checking bench for icap_stream_ctrl: a vector table of directed
// transactions, hand-written corner sequences and randomized transactions
// checked against a transaction-level model of the ICAP streams.
`timescale 1ns/1ps
module tb_icap_stream_ctrl;
    localparam int RD_LEN_W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                s_valid = 1'b0;
    logic [31:0]         s_data = '0;
    logic                s_last = 1'b0;
    logic                s_ready;
    logic                rd_start = 1'b0;
    logic [RD_LEN_W-1:0] rd_len = '0;
    logic                rb_valid;
    logic [31:0]         rb_data;
    logic                wr_done, rd_done;
    logic                cclk, ccs_n, cwe_n;
    logic [31:0]         cdata;
    logic                cbusy = 1'b0;
    logic [31:0]         cdata_rb = '0;

    icap_stream_ctrl #(.RD_LEN_W(RD_LEN_W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .rd_start(rd_start), .rd_len(rd_len),
        .rb_valid(rb_valid), .rb_data(rb_data),
        .wr_done(wr_done), .rd_done(rd_done),
        .cclk(cclk), .ccs_n(ccs_n), .cwe_n(cwe_n), .cdata(cdata),
        .cbusy(cbusy), .cdata_rb(cdata_rb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] obs_wr[$];
    int          obs_wr_cyc[$];
    logic [31:0] obs_rb[$];
    int          n_wr_done, n_rd_done, n_ccs_low, rd_done_cyc;
    logic        prev_ccs = 1'b1, prev_cwe = 1'b1;

    logic [31:0] wr_q[$];
    int          wr_idx = 0;
    logic [31:0] rb_src = '0;

    typedef struct {
        bit          is_read;
        int          len;
        logic [31:0] base;
        int          busy_from;
        int          busy_n;
        int          exp_calls;
        int          exp_words;
    } vec_t;

    vec_t vecs[7];

    // Expected ICAP word for a stream word: bytes bit-reversed when the
    // swap option is built in, untouched otherwise.
    function automatic logic [31:0] ref_map(input logic [31:0] d);
        logic [31:0] r;
        logic [7:0]  b;
        r = d;
`ifdef ICAP_BITSWAP_EN
        for (int k = 0; k < 4; k++) begin
            b = d[8*k +: 8];
            r[8*k +: 8] = {<<{b}};
        end
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus monitor: collects what the DUT puts on the ICAP and user side.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            prev_ccs = ccs_n;
            prev_cwe = cwe_n;
        end else begin
            if (!ccs_n && !cwe_n) begin
                obs_wr.push_back(cdata);
                obs_wr_cyc.push_back(cyc);
            end
            if (!ccs_n) n_ccs_low++;
            if (rb_valid) obs_rb.push_back(rb_data);
            if (wr_done) n_wr_done++;
            if (rd_done) begin
                n_rd_done++;
                rd_done_cyc = cyc;
            end
            if (cwe_n !== prev_cwe)
                chk("cwe_change_while_selected", {30'd0, prev_ccs, ccs_n}, 32'd3);
            prev_ccs = ccs_n;
            prev_cwe = cwe_n;
        end
    end

    // One clock of stimulus; returns 2ns after the rising edge.
    task automatic drive_cycle(input bit want_v, input bit busy, input bit start,
                               input logic [RD_LEN_W-1:0] len);
        bit acc, cap;
        s_valid  = want_v && (wr_idx < wr_q.size());
        s_data   = (wr_idx < wr_q.size()) ? wr_q[wr_idx] : 32'h0;
        s_last   = (wr_idx == wr_q.size() - 1);
        cbusy    = busy;
        rd_start = start;
        rd_len   = len;
        cdata_rb = rb_src;
        #1;
        if (busy) chk("s_ready_low_when_busy", {31'd0, s_ready}, 32'd0);
        acc = s_valid && s_ready;
        cap = !ccs_n && cwe_n && !cbusy;
        @(posedge clk);
        #2;
        if (acc) wr_idx++;
        if (cap) rb_src++;
        rd_start = 1'b0;
    endtask

    task automatic clear_obs();
        obs_wr.delete();
        obs_wr_cyc.delete();
        obs_rb.delete();
        n_wr_done = 0;
        n_rd_done = 0;
        n_ccs_low = 0;
        wr_idx = 0;
    endtask

    // Runs one transaction; wr_q / rb_src must be prepared by the caller.
    task automatic run_txn(input bit is_read, input int len, input int busy_from,
                           input int busy_n, input bit rnd, output int calls);
        bit done, busy, v, st;
        logic [RD_LEN_W-1:0] l;
        clear_obs();
        calls = 0;
        done = 1'b0;
        while (!done && calls < 200) begin
            busy = rnd ? ($urandom_range(0, 9) < 3)
                       : (calls >= busy_from && calls < busy_from + busy_n);
            v  = (calls == 0) ? 1'b1 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            st = (calls == 0) ? is_read : (rnd && !is_read && $urandom_range(0, 4) == 0);
            l  = (calls == 0) ? RD_LEN_W'(len) : RD_LEN_W'($urandom_range(1, 5));
            drive_cycle(v, busy, st, st ? l : '0);
            calls++;
            done = is_read ? (n_rd_done > 0) : (n_wr_done > 0);
        end
        chk("txn_done_seen", {31'd0, done}, 32'd1);
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_txn(input bit is_read, input int len, input logic [31:0] base);
        if (is_read) begin
            chk("rb_count", 32'(obs_rb.size()), 32'(len));
            chk("wr_count_during_read", 32'(obs_wr.size()), 32'd0);
            for (int i = 0; i < obs_rb.size() && i < len; i++)
                chk("rb_data", obs_rb[i], ref_map(base + 32'(i)));
            chk("rd_done_count", 32'(n_rd_done), 32'd1);
            chk("wr_done_during_read", 32'(n_wr_done), 32'd0);
        end else begin
            chk("wr_count", 32'(obs_wr.size()), 32'(wr_q.size()));
            chk("rb_count_during_write", 32'(obs_rb.size()), 32'd0);
            for (int i = 0; i < obs_wr.size() && i < wr_q.size(); i++)
                chk("wr_data", obs_wr[i], ref_map(wr_q[i]));
            chk("wr_done_count", 32'(n_wr_done), 32'd1);
            chk("rd_done_during_write", 32'(n_rd_done), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int calls;
        int nlen;
        bit is_rd;
        logic [31:0] base;

        // is_read, len, base, busy_from, busy_n, exp_calls, exp_words
        vecs[0] = '{1'b0, 3, 32'h0000_0000, 0, 0, 6, 3};
        vecs[1] = '{1'b0, 5, 32'h0000_1000, 3, 2, 10, 5};
        vecs[2] = '{1'b1, 4, 32'h0000_0010, 0, 0, 7, 4};
        vecs[3] = '{1'b1, 0, 32'h0000_0050, 0, 0, 1, 0};
        vecs[4] = '{1'b1, 5, 32'h0000_0100, 4, 3, 11, 5};
        vecs[5] = '{1'b0, 1, 32'hDEAD_BEEF, 0, 0, 4, 1};
        vecs[6] = '{1'b1, 1, 32'hCAFE_0000, 0, 0, 4, 1};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ccs_n", {31'd0, ccs_n}, 32'd1);
        chk("rst_cwe_n", {31'd0, cwe_n}, 32'd1);
        chk("rst_cdata", cdata, 32'd0);
        chk("rst_rb_data", rb_data, 32'd0);
        chk("rst_rb_valid", {31'd0, rb_valid}, 32'd0);
        chk("rst_done", {30'd0, wr_done, rd_done}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("cclk_follows_clk", {31'd0, cclk}, {31'd0, clk});
        #1;
        rst = 1'b0;
        drive_cycle(1'b0, 1'b0, 1'b0, '0);

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            wr_q.delete();
            if (!vecs[i].is_read) begin
                if (i == 0) begin
                    wr_q.push_back(32'hAA99_5566);
                    wr_q.push_back(32'h2000_0000);
                    wr_q.push_back(32'h3000_8001);
                end else begin
                    for (int k = 0; k < vecs[i].len; k++)
                        wr_q.push_back(vecs[i].base + 32'(k));
                end
            end
            rb_src = vecs[i].base;
            run_txn(vecs[i].is_read, vecs[i].len, vecs[i].busy_from, vecs[i].busy_n,
                    1'b0, calls);
            chk("vec_latency", 32'(calls), 32'(vecs[i].exp_calls));
            chk("vec_words", vecs[i].is_read ? 32'(obs_rb.size()) : 32'(obs_wr.size()),
                32'(vecs[i].exp_words));
            check_txn(vecs[i].is_read, vecs[i].len, vecs[i].base);
            if (i == 0 && obs_wr.size() == 3) begin
`ifdef ICAP_BITSWAP_EN
                chk("first_word_on_icap", obs_wr[0], 32'h5599_AA66);
`else
                chk("first_word_on_icap", obs_wr[0], 32'hAA99_5566);
`endif
                chk("write_cycles_back_to_back", 32'(obs_wr_cyc[2] - obs_wr_cyc[0]), 32'd2);
            end
            if (vecs[i].is_read && vecs[i].len == 0)
                chk("zero_len_ccs_n_high", 32'(n_ccs_low), 32'd0);
        end

        // Simultaneous rd_start and s_valid: readback first, write afterwards.
        wr_q.delete();
        wr_q.push_back(32'h1111_1111);
        wr_q.push_back(32'h2222_2222);
        rb_src = 32'h40;
        clear_obs();
        calls = 0;
        while (n_wr_done == 0 && calls < 60) begin
            drive_cycle(1'b1, 1'b0, calls == 0, RD_LEN_W'(3));
            calls++;
        end
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        chk("prio_rb_count", 32'(obs_rb.size()), 32'd3);
        for (int i = 0; i < obs_rb.size() && i < 3; i++)
            chk("prio_rb_data", obs_rb[i], ref_map(32'h40 + 32'(i)));
        chk("prio_wr_count", 32'(obs_wr.size()), 32'd2);
        for (int i = 0; i < obs_wr.size() && i < 2; i++)
            chk("prio_wr_data", obs_wr[i], ref_map(wr_q[i]));
        chk("prio_done_counts", {16'(n_rd_done), 16'(n_wr_done)}, {16'd1, 16'd1});
        if (obs_wr.size() > 0)
            chk("prio_read_before_write", {31'd0, rd_done_cyc < obs_wr_cyc[0]}, 32'd1);

        // Reset in the middle of a 5-word readback.
        wr_q.delete();
        rb_src = 32'h200;
        clear_obs();
        drive_cycle(1'b0, 1'b0, 1'b1, RD_LEN_W'(5));
        calls = 0;
        while (obs_rb.size() < 2 && calls < 20) begin
            drive_cycle(1'b0, 1'b0, 1'b0, '0);
            calls++;
        end
        chk("midread_two_words", 32'(obs_rb.size()), 32'd2);
        rst = 1'b1;
        #1;
        chk("midrst_ccs_n", {31'd0, ccs_n}, 32'd1);
        chk("midrst_cwe_n", {31'd0, cwe_n}, 32'd1);
        chk("midrst_cdata", cdata, 32'd0);
        chk("midrst_rb_data", rb_data, 32'd0);
        chk("midrst_rb_valid", {31'd0, rb_valid}, 32'd0);
        chk("midrst_done", {30'd0, wr_done, rd_done}, 32'd0);
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        chk("midrst_no_rd_done", 32'(n_rd_done), 32'd0);
        chk("midrst_no_more_words", 32'(obs_rb.size()), 32'd2);
        rb_src = 32'h300;
        run_txn(1'b1, 2, 0, 0, 1'b0, calls);
        check_txn(1'b1, 2, 32'h300);

        // Randomized transactions against the stream model.
        for (int t = 0; t < 40; t++) begin
            is_rd = $urandom_range(0, 1) == 1;
            base  = $urandom;
            wr_q.delete();
            if (is_rd) begin
                nlen = $urandom_range(0, 8);
            end else begin
                nlen = $urandom_range(1, 6);
                for (int k = 0; k < nlen; k++) wr_q.push_back($urandom);
            end
            rb_src = base;
            run_txn(is_rd, nlen, 0, 0, 1'b1, calls);
            check_txn(is_rd, nlen, base);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
